// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and RAM geometry for the load/store access unit.
package mem_pkg;

    localparam int RAM_DEPTH      = 2048;
    localparam int PORT_WORD_ADDR = 1;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Illegal size encodings count as misaligned so one flag covers both cases.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction/extension for loads and read-modify-write merge for sub-word stores.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and half lanes of the RAM word.
    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        if (i_offset[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
    end

    // Zero/sign-extend the selected lane; word loads pass through regardless of sign.
    always_comb begin
        case (i_size)
            SZ_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            SZ_WORD: o_load_data = i_rdata;
            default: o_load_data = 32'h0000_0000;
        endcase
    end

    // Overlay the right-aligned store data onto the addressed lane.
    always_comb begin
        o_merge_data = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                case (i_offset)
                    2'd0:    o_merge_data[7:0]   = i_wdata[7:0];
                    2'd1:    o_merge_data[15:8]  = i_wdata[7:0];
                    2'd2:    o_merge_data[23:16] = i_wdata[7:0];
                    2'd3:    o_merge_data[31:24] = i_wdata[7:0];
                    default: o_merge_data        = i_rdata;
                endcase
            end
            SZ_HALF: begin
                if (i_offset[1]) begin
                    o_merge_data[31:16] = i_wdata[15:0];
                end else begin
                    o_merge_data[15:0]  = i_wdata[15:0];
                end
            end
            SZ_WORD: o_merge_data = i_wdata;
            default: o_merge_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-wide RAM with combinational read.
// Sub-word stores are read-modify-write; all outputs are registered.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = $clog2(RAM_DEPTH),
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_wen;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [1:0]          r_offset;
    logic [1:0]          r_size;
    logic                r_signed;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic                r_err;

    logic                w_accept;
    logic                w_req_err;
    logic [31:0]         w_load_data;
    logic [31:0]         w_merge_data;
    logic                w_mem_wen_nxt;
    logic                w_rsp_valid_nxt;
    logic                w_rsp_err_nxt;
    logic                w_rdata_capture;
    logic                w_rdata_hold;
    logic                w_wdata_direct;
    logic                w_wdata_merge;

    mem_lane_align u_align (
        .i_rdata      (mem_rdata),
        .i_wdata      (r_wdata),
        .i_offset     (r_offset),
        .i_size       (r_size),
        .i_signed     (r_signed),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Request acceptance and rejection decode.
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && req_valid;
        w_req_err = size_misaligned(req_size, req_addr[1:0]) || (|req_addr[31:ADDR_W+2]);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!req_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_req_err) begin
                    w_state_nxt = ST_RESP;
                end else if (!req_we) begin
                    w_state_nxt = ST_LOAD;
                end else if (req_size == SZ_WORD) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_MERGE;
                end
            end
            ST_LOAD:  w_state_nxt = ST_RESP;
            ST_MERGE: w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode; drives register updates one edge ahead of the visible outputs.
    always_comb begin
        w_mem_wen_nxt   = (w_state_nxt == ST_WRITE);
        w_rsp_valid_nxt = (r_state == ST_RESP);
        w_rsp_err_nxt   = (r_state == ST_RESP) && r_err;
        w_rdata_capture = (r_state == ST_LOAD) && !r_we;
        w_rdata_hold    = (r_state == ST_RESP);
        w_wdata_direct  = w_accept && req_we && (req_size == SZ_WORD) && !w_req_err;
        w_wdata_merge   = (r_state == ST_MERGE);
    end

    // Handshake and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
        end else begin
            r_req_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            // Load data is held through RESP so it lines up with the rsp_valid pulse.
            if (w_rdata_capture) begin
                r_rsp_rdata <= w_load_data;
            end else if (!w_rdata_hold) begin
                r_rsp_rdata <= 32'h0000_0000;
            end
        end
    end

    // Latched request fields and RAM-side registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_offset    <= 2'b00;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= 32'h0000_0000;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_wen <= w_mem_wen_nxt;
            if (w_accept) begin
                r_offset   <= req_addr[1:0];
                r_size     <= req_size;
                r_signed   <= req_signed;
                r_we       <= req_we;
                r_wdata    <= req_wdata;
                r_err      <= w_req_err;
                r_mem_addr <= req_addr[ADDR_W+1:2];
            end
            if (w_wdata_direct) begin
                r_mem_wdata <= req_wdata;
            end else if (w_wdata_merge) begin
                r_mem_wdata <= w_merge_data;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wen   = r_mem_wen;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of load/store vectors against a behavioural RAM,
// plus hand-written reset-abort and back-to-back sequences.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [10:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:2047] = '{default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge, then watch up to 10 negedges for writes and the response.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err,
                           output int wen_n, output logic [31:0] wen_addr, output logic [31:0] wen_data);
        lat = -1; rdata = 32'h0; err = 1'b0; wen_n = 0; wen_addr = 32'h0; wen_data = 32'h0;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 1'b0;
            if (mem_wen) begin
                wen_n++;
                wen_addr = 32'(mem_addr);
                wen_data = mem_wdata;
            end
            if (rsp_valid) begin
                lat = k; rdata = rsp_rdata; err = rsp_err;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          wen;
        logic [31:0] mwdata;
        logic [31:0] word1;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int          lat, wen_n, wcnt, rcnt;
        logic [31:0] rdata, wen_addr, wen_data, tmp, a_addr;
        logic        err;
        int          rsp_k [2];
        logic [31:0] rsp_d [2];
        logic        rdy [3];

        // we, size, sgn, addr, wdata, latency, rdata, err, writes, write data, word 1 afterwards
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h4,    32'hDEADBEEF, 2, 32'h0,        1'b0, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 32'h6,    32'h0000005A, 3, 32'h0,        1'b0, 1, 32'hDE5ABEEF, 32'hDE5ABEEF};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h7,    32'h0,        2, 32'hFFFFFFDE, 1'b0, 0, 32'h0,        32'hDE5ABEEF};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h7,    32'h0,        2, 32'h000000DE, 1'b0, 0, 32'h0,        32'hDE5ABEEF};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h4,    32'h0,        2, 32'hFFFFBEEF, 1'b0, 0, 32'h0,        32'hDE5ABEEF};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h3,    32'h0,        1, 32'h0,        1'b1, 0, 32'h0,        32'hDE5ABEEF};
        vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h2000, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0,        32'hDE5ABEEF};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h4,    32'h0,        2, 32'hDE5ABEEF, 1'b0, 0, 32'h0,        32'hDE5ABEEF};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h6,    32'hAAAA1234, 3, 32'h0,        1'b0, 1, 32'h1234BEEF, 32'h1234BEEF};
        vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h4,    32'hFFFFFF77, 3, 32'h0,        1'b0, 1, 32'h1234BE77, 32'h1234BE77};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h6,    32'h0,        2, 32'h00001234, 1'b0, 0, 32'h0,        32'h1234BE77};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 32'h5,    32'h0,        2, 32'hFFFFFFBE, 1'b0, 0, 32'h0,        32'h1234BE77};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 32'h4,    32'h12345678, 1, 32'h0,        1'b1, 0, 32'h0,        32'h1234BE77};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h5,    32'h12345678, 1, 32'h0,        1'b1, 0, 32'h0,        32'h1234BE77};
        vecs[14] = '{1'b0, 2'b10, 1'b1, 32'h4,    32'h0,        2, 32'h1234BE77, 1'b0, 0, 32'h0,        32'h1234BE77};

        // Reset values while rst is held.
        @(negedge clk);
        chk("reset_ready",     32'(req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_rdata", rsp_rdata,      32'h0);
        chk("reset_rsp_err",   32'(rsp_err),   32'h0);
        chk("reset_mem_addr",  32'(mem_addr),  32'h0);
        chk("reset_mem_wen",   32'(mem_wen),   32'h0);
        chk("reset_mem_wdata", mem_wdata,      32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'h1);
            run_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    lat, rdata, err, wen_n, wen_addr, wen_data);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("v%0d_wen_count", i), 32'(wen_n), 32'(vecs[i].wen));
            if (vecs[i].wen > 0) begin
                a_addr = vecs[i].addr;
                chk($sformatf("v%0d_wen_addr", i), wen_addr, 32'(a_addr[12:2]));
                chk($sformatf("v%0d_wen_data", i), wen_data, vecs[i].mwdata);
            end
            chk($sformatf("v%0d_port_word", i), ram[PORT_WORD_ADDR], vecs[i].word1);
            if (i == 0) begin
                tmp = ram[PORT_WORD_ADDR];
                chk("v0_port_byte", 32'(tmp[7:0]), 32'h000000EF);
            end
        end

        // Reset pulsed while a byte store sits in MERGE.
        chk("abort_ready_before", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h00000000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_ready_in_rst",  32'(req_ready), 32'h1);
        chk("abort_wen_in_rst",    32'(mem_wen),   32'h0);
        chk("abort_valid_in_rst",  32'(rsp_valid), 32'h0);
        chk("abort_addr_in_rst",   32'(mem_addr),  32'h0);
        chk("abort_wdata_in_rst",  mem_wdata,      32'h0);
        wcnt = 0; rcnt = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_wen) wcnt++;
            if (rsp_valid) rcnt++;
        end
        chk("abort_wen_count", 32'(wcnt), 32'h0);
        chk("abort_rsp_count", 32'(rcnt), 32'h0);
        chk("abort_port_word", ram[PORT_WORD_ADDR], 32'h1234BE77);

        // Two loads with req_valid held high throughout.
        rsp_k[0] = -1; rsp_k[1] = -1; rsp_d[0] = 32'h0; rsp_d[1] = 32'h0; rcnt = 0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h0;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_size = 2'b00; req_addr = 32'h6;
            end
            if (k == 3) req_valid = 1'b0;
            if (k < 3) rdy[k] = req_ready;
            if (rsp_valid) begin
                if (rcnt < 2) begin
                    rsp_k[rcnt] = k;
                    rsp_d[rcnt] = rsp_rdata;
                end
                rcnt++;
            end
        end
        chk("b2b_ready_k0",  32'(rdy[0]),   32'h0);
        chk("b2b_ready_k1",  32'(rdy[1]),   32'h0);
        chk("b2b_ready_k2",  32'(rdy[2]),   32'h1);
        chk("b2b_rsp_count", 32'(rcnt),     32'h2);
        chk("b2b_rsp0_time", 32'(rsp_k[0]), 32'h2);
        chk("b2b_rsp0_data", rsp_d[0],      32'h1234BE77);
        chk("b2b_rsp1_time", 32'(rsp_k[1]), 32'h5);
        chk("b2b_rsp1_data", rsp_d[1],      32'h00000034);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
